// File: rtl/comparator_bist.sv
// comparator_bist: built-in self-test sequencer for a WIDTH-bit magnitude
// comparator. It sweeps every (a, b) pair, checks {eq, less, greater}
// against the expected result and reports pass/fail, a saturating error
// count and the first failing vector. It is controlled by a start/done
// handshake.
module comparator_bist #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             eq_in,
  input  logic             less_in,
  input  logic             greater_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [2:0]       fail_flags
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    vec_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic [2:0]       fail_flags_q;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [2:0]       exp_flags;
  logic [2:0]       obs_flags;
  logic             vec_fail;
  logic             last_vec;
  logic [ERR_W-1:0] err_d;

  // The vector counter holds a in its upper half and b in its lower half,
  // so a plain increment walks b fastest.
  assign cur_a     = vec_q[CW-1:WIDTH];
  assign cur_b     = vec_q[WIDTH-1:0];
  assign exp_flags = {cur_a == cur_b, cur_a < cur_b, cur_a > cur_b};
  assign obs_flags = {eq_in, less_in, greater_in};
  // Any difference fails, including non-one-hot flag combinations.
  assign vec_fail  = (obs_flags != exp_flags);
  assign last_vec  = &vec_q;
  // The error counter saturates at all-ones instead of wrapping.
  assign err_d     = (vec_fail && !(&err_q)) ? err_q + ERR_W'(1) : err_q;

  // Sweep sequencer: IDLE/DONE wait for start, DRIVE gives the comparator a
  // settle cycle, and CHECK samples the flags and advances the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_flags_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_DRIVE;
            vec_q        <= '0;
            err_q        <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_flags_q <= '0;
          end
        end
        S_DRIVE: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          // Only the first failure of a sweep is captured.
          if (vec_fail && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_a_q     <= cur_a;
            fail_b_q     <= cur_b;
            fail_flags_q <= obs_flags;
          end
          if (last_vec) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= S_DRIVE;
            vec_q   <= vec_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out      = cur_a;
  assign b_out      = cur_b;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_flags = fail_flags_q;

endmodule

// File: tb/tb_comparator_bist.sv
// tb_comparator_bist: exercises comparator_bist against a behavioural
// comparator with selectable faults. Three instances share the clock and
// reset: WIDTH=2/ERR_W=8, WIDTH=2/ERR_W=3 and WIDTH=3/ERR_W=8.
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       start_r;
  int         sel;
  int         mode;
  logic [2:0] rand_tab [64];
  int         total;
  int         bad;

  // Comparator under test: 0 correct, 1 eq stuck 0, 2 less/greater swapped,
  // 3 all flags stuck 1, 4 flags taken from a random table.
  function automatic logic [2:0] cmp_model(input int a, input int b, input int md,
                                           input logic [2:0] tab);
    logic [2:0] r;
    r = {a == b, a < b, a > b};
    case (md)
      1:       r = {1'b0, a < b, a > b};
      2:       r = {a == b, a > b, a < b};
      3:       r = 3'b111;
      4:       r = tab;
      default: r = {a == b, a < b, a > b};
    endcase
    return r;
  endfunction

  // Instance 0: WIDTH=2, ERR_W=8
  logic [1:0] a0, b0, fa0, fb0;
  logic       eq0, lt0, gt0, busy0, done0, pass0, fv0, start0;
  logic [7:0] err0;
  logic [2:0] ff0;
  assign start0 = start_r && (sel == 0);
  assign {eq0, lt0, gt0} = cmp_model(int'(a0), int'(b0), mode, rand_tab[{2'b00, a0, b0}]);

  comparator_bist #(.WIDTH(2), .ERR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
    .eq_in(eq0), .less_in(lt0), .greater_in(gt0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_valid(fv0), .fail_a(fa0),
    .fail_b(fb0), .fail_flags(ff0));

  // Instance 1: WIDTH=2, ERR_W=3
  logic [1:0] a1, b1, fa1, fb1;
  logic       eq1, lt1, gt1, busy1, done1, pass1, fv1, start1;
  logic [2:0] err1;
  logic [2:0] ff1;
  assign start1 = start_r && (sel == 1);
  assign {eq1, lt1, gt1} = cmp_model(int'(a1), int'(b1), mode, rand_tab[{2'b00, a1, b1}]);

  comparator_bist #(.WIDTH(2), .ERR_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .eq_in(eq1), .less_in(lt1), .greater_in(gt1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_a(fa1),
    .fail_b(fb1), .fail_flags(ff1));

  // Instance 2: WIDTH=3, ERR_W=8
  logic [2:0] a2, b2, fa2, fb2;
  logic       eq2, lt2, gt2, busy2, done2, pass2, fv2, start2;
  logic [7:0] err2;
  logic [2:0] ff2;
  assign start2 = start_r && (sel == 2);
  assign {eq2, lt2, gt2} = cmp_model(int'(a2), int'(b2), mode, rand_tab[{a2, b2}]);

  comparator_bist #(.WIDTH(3), .ERR_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .eq_in(eq2), .less_in(lt2), .greater_in(gt2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_a(fa2),
    .fail_b(fb2), .fail_flags(ff2));

  // View of the currently selected instance
  logic obs_busy, obs_done, obs_pass, obs_fv;
  int   obs_err, obs_a, obs_b, obs_fa, obs_fb, obs_ff;
  always_comb begin
    obs_busy = 1'b0; obs_done = 1'b0; obs_pass = 1'b0; obs_fv = 1'b0;
    obs_err = 0; obs_a = 0; obs_b = 0; obs_fa = 0; obs_fb = 0; obs_ff = 0;
    case (sel)
      0: begin
        obs_busy = busy0; obs_done = done0; obs_pass = pass0; obs_fv = fv0;
        obs_err = int'(err0); obs_a = int'(a0); obs_b = int'(b0);
        obs_fa = int'(fa0); obs_fb = int'(fb0); obs_ff = int'(ff0);
      end
      1: begin
        obs_busy = busy1; obs_done = done1; obs_pass = pass1; obs_fv = fv1;
        obs_err = int'(err1); obs_a = int'(a1); obs_b = int'(b1);
        obs_fa = int'(fa1); obs_fb = int'(fb1); obs_ff = int'(ff1);
      end
      default: begin
        obs_busy = busy2; obs_done = done2; obs_pass = pass2; obs_fv = fv2;
        obs_err = int'(err2); obs_a = int'(a2); obs_b = int'(b2);
        obs_fa = int'(fa2); obs_fb = int'(fb2); obs_ff = int'(ff2);
      end
    endcase
  end

  // Pulse (or hold) start, then count busy cycles until the sweep ends.
  task automatic run_sweep(input bit hold, output int bcyc);
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_r = 1'b0;
    bcyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (obs_busy) bcyc++;
      else break;
    end
    start_r = 1'b0;
  endtask

  // Reference: walk all vectors in sweep order and score them.
  task automatic ref_model(input int nb, input int errmax, output int e,
                           output int fv, output int fa, output int fb, output int ff);
    logic [2:0] got, want;
    e = 0; fv = 0; fa = 0; fb = 0; ff = 0;
    for (int a = 0; a < nb; a++) begin
      for (int b = 0; b < nb; b++) begin
        want = {a == b, a < b, a > b};
        got  = cmp_model(a, b, mode, rand_tab[a * nb + b]);
        if (got != want) begin
          if (e < errmax) e++;
          if (fv == 0) begin
            fv = 1; fa = a; fb = b; ff = int'(got);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #1 rst_n = 1'b0;
    #2;
    total++; if ({obs_busy, obs_done, obs_pass, obs_fv} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {obs_busy, obs_done, obs_pass, obs_fv}); end
    total++; if ((obs_err | obs_a | obs_b | obs_fa | obs_fb | obs_ff) !== 0) begin
      bad++; $display("FAIL reset_values err=%0d a=%0d b=%0d fa=%0d fb=%0d ff=%0d want all 0",
                      obs_err, obs_a, obs_b, obs_fa, obs_fb, obs_ff); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({obs_busy, obs_done, obs_err} !== 0) begin
      bad++; $display("FAIL reset_idle busy=%0b done=%0b err=%0d want 0", obs_busy, obs_done, obs_err); end
  endtask

  task automatic test_correct(input int s, input int nvec);
    int bc;
    sel = s; mode = 0;
    run_sweep(1'b0, bc);
    total++; if (bc !== 2 * nvec) begin
      bad++; $display("FAIL correct_busy_cycles sel=%0d got=%0d want=%0d", s, bc, 2 * nvec); end
    total++; if ({obs_done, obs_pass, obs_fv} !== 3'b110) begin
      bad++; $display("FAIL correct_done_pass_fv sel=%0d got=%b want=110", s, {obs_done, obs_pass, obs_fv}); end
    total++; if (obs_err !== 0) begin
      bad++; $display("FAIL correct_err sel=%0d got=%0d want=0", s, obs_err); end
    $display("sweep sel=%0d mode=0 busy=%0d err=%0d pass=%0b", s, bc, obs_err, obs_pass);
  endtask

  task automatic test_eq_stuck();
    int bc;
    sel = 0; mode = 1;
    run_sweep(1'b0, bc);
    total++; if (obs_err !== 4) begin
      bad++; $display("FAIL eqstuck_err got=%0d want=4", obs_err); end
    total++; if ({obs_fv, obs_pass} !== 2'b10) begin
      bad++; $display("FAIL eqstuck_fv_pass got=%b want=10", {obs_fv, obs_pass}); end
    total++; if ({obs_fa, obs_fb, obs_ff} !== {32'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL eqstuck_capture got=%0d,%0d,%0d want=0,0,0", obs_fa, obs_fb, obs_ff); end
    $display("sweep sel=0 mode=1 busy=%0d err=%0d first=(%0d,%0d,%03b)", bc, obs_err, obs_fa, obs_fb, obs_ff[2:0]);
  endtask

  task automatic test_swap();
    int bc;
    sel = 0; mode = 2;
    run_sweep(1'b0, bc);
    total++; if (obs_err !== 12) begin
      bad++; $display("FAIL swap_err got=%0d want=12", obs_err); end
    total++; if ({obs_fa, obs_fb, obs_ff} !== {32'd0, 32'd1, 32'd1}) begin
      bad++; $display("FAIL swap_capture got=%0d,%0d,%0d want=0,1,1", obs_fa, obs_fb, obs_ff); end
    total++; if (obs_pass !== 1'b0) begin
      bad++; $display("FAIL swap_pass got=%0b want=0", obs_pass); end
    $display("sweep sel=0 mode=2 busy=%0d err=%0d first=(%0d,%0d,%03b)", bc, obs_err, obs_fa, obs_fb, obs_ff[2:0]);
  endtask

  task automatic test_restart_from_done();
    int n;
    sel = 0; mode = 0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    total++; if ({obs_busy, obs_done, obs_pass, obs_fv} !== 4'b1000 || obs_err !== 0) begin
      bad++; $display("FAIL restart_clear busy/done/pass/fv=%b err=%0d want 1000 err 0",
                      {obs_busy, obs_done, obs_pass, obs_fv}, obs_err); end
    n = 0;
    while (!obs_done && n < 200) begin @(negedge clk); n++; end
    total++; if (!(obs_done && obs_pass && obs_err == 0)) begin
      bad++; $display("FAIL restart_result done=%0b pass=%0b err=%0d want 1 1 0", obs_done, obs_pass, obs_err); end
    $display("restart sel=0 err=%0d pass=%0b", obs_err, obs_pass);
  endtask

  task automatic test_start_while_busy();
    int bc;
    sel = 0; mode = 0;
    run_sweep(1'b1, bc);
    total++; if (bc !== 32) begin
      bad++; $display("FAIL heldstart_busy_cycles got=%0d want=32", bc); end
    total++; if ({obs_done, obs_pass} !== 2'b11) begin
      bad++; $display("FAIL heldstart_done_pass got=%b want=11", {obs_done, obs_pass}); end
    $display("held start busy=%0d pass=%0b", bc, obs_pass);
  endtask

  task automatic test_saturate();
    int bc;
    sel = 1; mode = 3;
    run_sweep(1'b0, bc);
    total++; if (obs_err !== 7) begin
      bad++; $display("FAIL sat_err got=%0d want=7", obs_err); end
    total++; if ({obs_fa, obs_fb, obs_ff} !== {32'd0, 32'd0, 32'd7} || obs_fv !== 1'b1) begin
      bad++; $display("FAIL sat_capture got=%0d,%0d,%0d fv=%0b want=0,0,7 fv=1", obs_fa, obs_fb, obs_ff, obs_fv); end
    $display("sweep sel=1 mode=3 busy=%0d err=%0d", bc, obs_err);
  endtask

  task automatic test_random(input int iters);
    int bc, e, fv, fa, fb, ff;
    logic [2:0] good;
    sel = 0; mode = 4;
    for (int it = 0; it < iters; it++) begin
      for (int i = 0; i < 64; i++) begin
        good = {(i / 4) == (i % 4), (i / 4) < (i % 4), (i / 4) > (i % 4)};
        rand_tab[i] = ($urandom_range(0, 2) != 0) ? good : 3'($urandom_range(0, 7));
      end
      run_sweep(1'b0, bc);
      ref_model(4, 255, e, fv, fa, fb, ff);
      total++; if (obs_err !== e) begin
        bad++; $display("FAIL rand_err it=%0d got=%0d want=%0d", it, obs_err, e); end
      total++; if (obs_fv !== fv[0] || obs_pass !== (e == 0)) begin
        bad++; $display("FAIL rand_fv_pass it=%0d got=%0b,%0b want=%0b,%0b", it, obs_fv, obs_pass, fv[0], e == 0); end
      total++; if ({obs_fa, obs_fb, obs_ff} !== {fa, fb, ff}) begin
        bad++; $display("FAIL rand_capture it=%0d got=%0d,%0d,%0d want=%0d,%0d,%0d",
                        it, obs_fa, obs_fb, obs_ff, fa, fb, ff); end
      $display("random it=%0d err=%0d first=(%0d,%0d,%03b)", it, obs_err, obs_fa, obs_fb, obs_ff[2:0]);
    end
  endtask

  task automatic test_reset_midsweep();
    int bc;
    sel = 0; mode = 0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if ({obs_a, obs_b} !== {32'd1, 32'd1} || obs_busy !== 1'b1) begin
      bad++; $display("FAIL midsweep_vec5 got a=%0d b=%0d busy=%0b want 1 1 1", obs_a, obs_b, obs_busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({obs_busy, obs_done, obs_pass, obs_fv} !== 4'b0000 ||
                 (obs_err | obs_a | obs_b | obs_fa | obs_fb | obs_ff) !== 0) begin
      bad++; $display("FAIL midsweep_abort flags=%b err=%0d a=%0d b=%0d want all 0",
                      {obs_busy, obs_done, obs_pass, obs_fv}, obs_err, obs_a, obs_b); end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(1'b0, bc);
    total++; if (bc !== 32 || obs_pass !== 1'b1) begin
      bad++; $display("FAIL midsweep_rerun busy=%0d pass=%0b want 32 1", bc, obs_pass); end
    $display("reset midsweep rerun busy=%0d pass=%0b", bc, obs_pass);
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; mode = 0; start_r = 1'b0;
    for (int i = 0; i < 64; i++) rand_tab[i] = 3'b000;
    test_reset();
    test_correct(0, 16);
    test_eq_stuck();
    test_swap();
    test_restart_from_done();
    test_start_while_busy();
    test_saturate();
    test_random(4);
    test_reset_midsweep();
    test_correct(2, 64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
